fetch_ifid: RTL and testbench



---
 rtl/fetch_ifid.sv | 59 +++++
 tb/tb_fetch_ifid.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_ifid.sv
// LEGv8 instruction-fetch stage and IF/ID pipeline register.
// Handles load-use stalls, taken-branch flushes and instruction-memory wait cycles.
module fetch_ifid #(
    parameter int             N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_F,
    input  logic         PCSrc_M,
    input  logic [N-1:0] PCBranch_M,
    output logic [N-1:0] imem_addr_F,
    input  logic [31:0]  imem_data_F,
    input  logic         imem_ready_F,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic [10:0]  Op_D
);

    typedef struct packed {
        logic [31:0]  instr;
        logic [N-1:0] pc;
        logic         valid;
    } ifid_t;

    logic [N-1:0] pc;
    ifid_t        ifid;

    assign imem_addr_F = pc;

    // A taken branch beats a stall; a stall beats a memory wait.
    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (PCSrc_M)
            pc <= {PCBranch_M[N-1:2], 2'b00};
        else if (!stall_F && imem_ready_F)
            pc <= pc + N'(4);
    end

    // Flush and memory wait both leave an all-zero bubble so decode sees no control.
    always_ff @(posedge clk) begin
        if (reset || PCSrc_M)
            ifid <= '0;
        else if (stall_F)
            ifid <= ifid;
        else if (!imem_ready_F)
            ifid <= '0;
        else
            ifid <= '{instr: imem_data_F, pc: pc, valid: 1'b1};
    end

    assign instr_D = ifid.instr;
    assign pc_D    = ifid.pc;
    assign valid_D = ifid.valid;
    assign Op_D    = ifid.instr[31:21];

endmodule

// File: tb/tb_fetch_ifid.sv
// Scoreboarded random + directed bench for fetch_ifid against a rule-level reference model.
module tb_fetch_ifid;

    localparam int N = 64;
    localparam logic [N-1:0] RESET_PC = 64'h0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall_F = 1'b0;
    logic         PCSrc_M = 1'b0;
    logic [N-1:0] PCBranch_M = '0;
    logic [N-1:0] imem_addr_F;
    logic [31:0]  imem_data_F;
    logic         imem_ready_F = 1'b1;
    logic [31:0]  instr_D;
    logic [N-1:0] pc_D;
    logic         valid_D;
    logic [10:0]  Op_D;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_ifid #(.N(N), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stall_F(stall_F), .PCSrc_M(PCSrc_M),
        .PCBranch_M(PCBranch_M), .imem_addr_F(imem_addr_F), .imem_data_F(imem_data_F),
        .imem_ready_F(imem_ready_F), .instr_D(instr_D), .pc_D(pc_D),
        .valid_D(valid_D), .Op_D(Op_D)
    );

    // Instruction memory contents: LDUR at address 0, hashed words elsewhere.
    function automatic logic [31:0] word_at(input logic [N-1:0] a);
        if (a == 0) return 32'hF840_0000;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    assign imem_data_F = word_at(imem_addr_F);

    typedef struct {
        logic [N-1:0] addr;
        logic [31:0]  instr;
        logic [N-1:0] pcd;
        logic         valid;
    } exp_t;

    exp_t sb[$];

    // Reference model state: the architectural view of fetch and the ID slot.
    logic [N-1:0] m_pc = '0;
    logic [31:0]  m_instr = '0;
    logic [N-1:0] m_pcd = '0;
    logic         m_valid = 1'b0;

    task automatic step(input logic rst, input logic st, input logic br,
                        input logic [N-1:0] tgt, input logic rdy);
        exp_t e;
        @(negedge clk);
        reset = rst; stall_F = st; PCSrc_M = br; PCBranch_M = tgt; imem_ready_F = rdy;
        if (rst) begin
            m_pc = RESET_PC; m_instr = '0; m_pcd = '0; m_valid = 1'b0;
        end else if (br) begin
            m_instr = '0; m_pcd = '0; m_valid = 1'b0;
            m_pc = tgt - (tgt % 4);
        end else if (st) begin
            // everything frozen
        end else if (!rdy) begin
            m_instr = '0; m_pcd = '0; m_valid = 1'b0;
        end else begin
            m_instr = word_at(m_pc); m_pcd = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 4;
        end
        e.addr = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.valid = m_valid;
        sb.push_back(e);
    endtask

    task automatic check64(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every edge produces one observable IF/ID + PC state.
    always @(posedge clk) begin
        exp_t e;
        logic [31:0] ei;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            ei = e.instr;
            check64("imem_addr_F", imem_addr_F, e.addr);
            check64("instr_D", {32'h0, instr_D}, {32'h0, ei});
            check64("pc_D", pc_D, e.pcd);
            check64("valid_D", {63'h0, valid_D}, {63'h0, e.valid});
            check64("Op_D", {53'h0, Op_D}, {53'h0, ei[31:21]});
        end
    end

    initial begin
        logic [N-1:0] t;
        // reset, then free run fetching 0x0, 0x4, 0x8, 0xC
        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 1);
        repeat (4) step(0, 0, 0, '0, 1);
        // stall three cycles at PC 0x10, release
        repeat (3) step(0, 1, 0, '0, 1);
        repeat (2) step(0, 0, 0, '0, 1);
        // branch with simultaneous stall; unaligned target
        step(0, 1, 1, 64'h103, 1);
        repeat (2) step(0, 0, 0, '0, 1);
        // memory wait at 0x20, plus stall during wait
        step(0, 0, 1, 64'h20, 1);
        repeat (2) step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);
        step(0, 1, 0, '0, 0);
        step(0, 0, 0, '0, 1);
        // PC wrap at the top of the address space
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        repeat (3) step(0, 0, 0, '0, 1);
        // reset beats stall and branch
        step(0, 0, 0, '0, 1);
        step(1, 1, 1, 64'h500, 0);
        step(0, 0, 0, '0, 1);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            t = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | N'($urandom_range(0, 15));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, t, $urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
